// File: rtl/kp_pkg.sv
// rtl/kp_pkg.sv - shared types, constants and row-priority helper for the keypad scanner
package kp_pkg;

  typedef enum logic [1:0] {SCAN, DEB, HELD} kp_state_t;

  typedef logic [3:0] key_code_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Lowest-index active-low row wins when several rows are pulled down at once.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    if (!r[0]) return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else return 2'd3;
  endfunction

endpackage

// File: rtl/kp_tick.sv
// rtl/kp_tick.sv - free-running divider, one-clk tick every N clks
module kp_tick #(
  parameter int N = 10000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/kp_scan.sv
// rtl/kp_scan.sv - 4x4 matrix keypad scanner with press/release debounce
module kp_scan #(
  parameter int N   = 10000,
  parameter int DEB = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:1] row,
  output logic [4:1] col,
  output logic [3:0] key,
  output logic       key_vld,
  output logic       key_held
);
  import kp_pkg::*;

  localparam int CW = (DEB > 0) ? $clog2(DEB + 1) : 1;
  localparam logic [CW-1:0] DEB_C = CW'(DEB);

  logic            tick;
  logic [3:0]      rs_meta;
  logic [3:0]      rs;
  kp_state_t       state;
  logic [1:0]      r;
  logic [1:0]      col_idx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   rcnt;
  key_code_t       scan_code;

  kp_tick #(.N(N)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // rs bit i mirrors row[i+1] so the row index can address it directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_meta <= 4'b1111;
      rs      <= 4'b1111;
    end else begin
      rs_meta <= row;
      rs      <= rs_meta;
    end
  end

  assign scan_code = {low_row(rs), col_idx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SCAN;
      col      <= COL_RESET;
      col_idx  <= 2'd0;
      r        <= 2'd0;
      cnt      <= '0;
      rcnt     <= '0;
      key      <= 4'd0;
      key_vld  <= 1'b0;
      key_held <= 1'b0;
    end else begin
      key_vld <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (rs != 4'b1111) begin
              r <= low_row(rs);
              if (DEB == 1) begin
                state    <= HELD;
                cnt      <= DEB_C;
                rcnt     <= '0;
                key      <= scan_code;
                key_vld  <= 1'b1;
                key_held <= 1'b1;
              end else begin
                state <= kp_pkg::DEB;
                cnt   <= CW'(1);
              end
            end else begin
              col     <= {col[3:1], col[4]};
              col_idx <= col_idx + 2'd1;
            end
          end
          kp_pkg::DEB: begin
            if (!rs[r]) begin
              if (cnt + CW'(1) == DEB_C) begin
                state    <= HELD;
                cnt      <= DEB_C;
                rcnt     <= '0;
                key      <= {r, col_idx};
                key_vld  <= 1'b1;
                key_held <= 1'b1;
              end else if (cnt != DEB_C) begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              // Bounce: drop the candidate, leave the reported key alone.
              state   <= SCAN;
              cnt     <= '0;
              col     <= {col[3:1], col[4]};
              col_idx <= col_idx + 2'd1;
            end
          end
          HELD: begin
            if (rs[r]) begin
              if (rcnt + CW'(1) == DEB_C) begin
                state    <= SCAN;
                cnt      <= '0;
                rcnt     <= '0;
                key_held <= 1'b0;
                col      <= {col[3:1], col[4]};
                col_idx  <= col_idx + 2'd1;
              end else if (rcnt != DEB_C) begin
                rcnt <= rcnt + CW'(1);
              end
            end else begin
              rcnt <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kp_scan.sv
// tb/tb_kp_scan.sv - scoreboard bench for kp_scan with a modelled key matrix
module tb_kp_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:1]  row;
  logic [4:1]  col;
  logic [3:0]  key;
  logic        key_vld;
  logic        key_held;
  logic [15:0] keys;
  logic [3:0]  exp_q[$];
  logic [4:1]  e;
  int          checks;
  int          errors;
  int          n;

  kp_scan #(.N(4), .DEB(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key      (key),
    .key_vld  (key_vld),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // keys bit (r*4+c) closed pulls row r+1 low while column c+1 is strobed.
  always_comb begin
    row = 4'b1111;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (keys[rr*4+cc] && !col[cc+1]) row[rr+1] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic       prev;
    logic [3:0] ek;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && key_vld) begin
        chk("vld_one_clk", 32'(prev), 32'(0));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vld actual key=%h required=no pulse", key);
        end else begin
          ek = exp_q.pop_front();
          chk("key_on_vld", 32'(key), 32'(ek));
        end
      end
      prev = key_vld;
    end
  endtask

  task automatic wait_col(input logic [4:1] v);
    int k;
    k = 0;
    while (col == v && k < 50) begin @(negedge clk); k++; end
    while (col != v && k < 50) begin @(negedge clk); k++; end
    chk("wait_col", 32'(col), 32'(v));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    keys   = 16'h0000;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'({col, key, key_vld, key_held}), 32'({4'b1110, 4'h0, 2'b00}));
    rst = 1'b0;

    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = 4'b1110;
      for (int j = 0; j < (k / 4) % 4; j++) e = {e[3:1], e[4]};
      chk("idle_scan", 32'({col, key, key_vld, key_held}), 32'({e, 4'h0, 2'b00}));
    end

    exp_q.push_back(4'h9);
    keys = 16'h0200;
    for (int i = 0; i < 100 && !key_held; i++) @(negedge clk);
    chk("press_held", 32'(key_held), 32'(1));
    chk("press_col_frozen", 32'(col), 32'(4'b1101));
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("press_still_held", 32'({col, key_held}), 32'({4'b1101, 1'b1}));
    keys = 16'h0000;
    n = 0;
    while (key_held && n < 40) begin @(posedge clk); n++; @(negedge clk); end
    chk("release_latency", 32'(n), 32'(12));
    chk("release_col_key", 32'({col, key}), 32'({4'b1011, 4'h9}));

    wait_col(4'b1110);
    keys = 16'h0001;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bounce_deb_frozen", 32'(col), 32'(4'b1110));
    keys = 16'h0000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bounce_abort", 32'({col, key, key_held}), 32'({4'b1101, 4'h9, 1'b0}));

    exp_q.push_back(4'h3);
    keys = 16'h0088;
    for (int i = 0; i < 100 && !key_vld; i++) @(negedge clk);
    chk("two_row_vld", 32'(key_vld), 32'(1));
    keys = keys | 16'h8000;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("held_ignore", 32'({col, key, key_held}), 32'({4'b0111, 4'h3, 1'b1}));

    keys = 16'h0000;
    repeat (8) @(posedge clk);
    @(negedge clk);
    keys = 16'h0008;
    repeat (4) @(posedge clk);
    @(negedge clk);
    keys = 16'h0000;
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("glitch_hold", 32'(key_held), 32'(1));
    @(posedge clk);
    @(negedge clk);
    chk("glitch_release", 32'({col, key, key_held}), 32'({4'b1110, 4'h3, 1'b0}));

    keys = 16'h1000;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_pre_deb", 32'(col), 32'(4'b1110));
    rst = 1'b1;
    #1;
    chk("rst_async", 32'({col, key, key_vld, key_held}), 32'({4'b1110, 4'h0, 2'b00}));
    repeat (3) @(negedge clk);
    exp_q.push_back(4'hC);
    rst = 1'b0;
    n = 0;
    while (!key_held && n < 40) begin @(posedge clk); n++; @(negedge clk); end
    chk("rst_reaccept_latency", 32'(n), 32'(12));
    chk("rst_reaccept_key", 32'(key), 32'(4'hC));

    keys = 16'h0000;
    n = 0;
    while (key_held && n < 40) begin @(posedge clk); n++; @(negedge clk); end
    chk("final_release", 32'(key_held), 32'(0));
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
